// File: rtl/add_chain_pkg.sv
// Shared constants and reference function for the pipelined add chain.
// The ADD_CHAIN_PIPE_CNT_EN build adds an output transfer counter of ADD_CHAIN_CNT_W bits.
package add_chain_pkg;

    localparam int ADD_CHAIN_STAGES = 4;
    localparam int ADD_CHAIN_CNT_W  = 32;

    // Reference result {t3, t2} for word width w (even, 4..62) and increment inc.
    function automatic logic [63:0] add_chain_ref(
        input int unsigned w,
        input logic [63:0] inc,
        input logic [63:0] din
    );
        logic [63:0] mask_w;
        logic [63:0] mask_h;
        logic [63:0] t0;
        logic [63:0] t0l;
        logic [63:0] t1;
        logic [63:0] t2;
        logic [63:0] t3;
        int unsigned h;
        h      = w / 32'd2;
        mask_w = (64'd1 << w) - 64'd1;
        mask_h = (64'd1 << h) - 64'd1;
        t0     = (din + inc) & mask_w;
        t0l    = t0 & mask_h;
        t1     = (t0l + (din & mask_h)) & mask_h;
        t2     = (t1 + t0l) & mask_h;
        t3     = (t2 + t1) & mask_h;
        return (t3 << h) | t2;
    endfunction

endpackage

// File: rtl/add_chain_stage.sv
// One elastic register slice: holds a payload while valid, loads whenever it is
// empty or its content is being taken downstream in the same cycle.
module add_chain_stage #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_o
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;
    logic          load_s;

    assign ready_o = !valid_q || ready_i;
    assign load_s  = valid_i && ready_o;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Next-state: an open slice takes whatever is offered, a stalled one holds.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_o) begin
            valid_d = valid_i;
        end else begin
            valid_d = valid_q;
        end
        if (load_s) begin
            data_d = data_i;
        end else begin
            data_d = data_q;
        end
    end

    // Valid bit carries the only reset in the slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload register, reset-free.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule

// File: rtl/add_chain_pipe.sv
// Four-slice pipelined increment/half-width add chain with valid/ready flow control.
// Defining ADD_CHAIN_PIPE_CNT_EN adds the xfer_cnt output transfer counter.
module add_chain_pipe
    import add_chain_pkg::*;
#(
    parameter int          W   = 16,
    parameter int unsigned INC = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data
`ifdef ADD_CHAIN_PIPE_CNT_EN
    ,
    output logic [ADD_CHAIN_CNT_W-1:0] xfer_cnt
`endif
);

    localparam int H = W / 2;
    localparam logic [W-1:0] INC_W = W'(INC);

    logic [W-1:0] t0_s;
    logic         unused_t0_hi_s;
    logic [H-1:0] sum12_s;
    logic [H-1:0] sum23_s;
    logic [H-1:0] sum34_s;
    logic [W-1:0] pl1_in_s, pl2_in_s, pl3_in_s, pl4_in_s;
    logic [W-1:0] pl1_s, pl2_s, pl3_s, pl4_s;
    logic         v1_s, v2_s, v3_s, v4_s;
    logic         r1_s, r2_s, r3_s, r4_s;

    // Every slice after the first holds {hi, lo} and forwards {hi + lo, hi}, which
    // yields {t1,t0l}, {t2,t1} and {t3,t2} in turn.
    always_comb begin
        t0_s     = in_data + INC_W;
        pl1_in_s = {t0_s[H-1:0], in_data[H-1:0]};
        sum12_s  = pl1_s[W-1:H] + pl1_s[H-1:0];
        pl2_in_s = {sum12_s, pl1_s[W-1:H]};
        sum23_s  = pl2_s[W-1:H] + pl2_s[H-1:0];
        pl3_in_s = {sum23_s, pl2_s[W-1:H]};
        sum34_s  = pl3_s[W-1:H] + pl3_s[H-1:0];
        pl4_in_s = {sum34_s, pl3_s[W-1:H]};
    end

    assign unused_t0_hi_s = ^t0_s[W-1:H];

    add_chain_stage #(.DW(W)) u_s1 (
        .clk(clk), .rst(rst), .valid_i(in_valid), .ready_o(r1_s), .data_i(pl1_in_s),
        .valid_o(v1_s), .ready_i(r2_s), .data_o(pl1_s)
    );
    add_chain_stage #(.DW(W)) u_s2 (
        .clk(clk), .rst(rst), .valid_i(v1_s), .ready_o(r2_s), .data_i(pl2_in_s),
        .valid_o(v2_s), .ready_i(r3_s), .data_o(pl2_s)
    );
    add_chain_stage #(.DW(W)) u_s3 (
        .clk(clk), .rst(rst), .valid_i(v2_s), .ready_o(r3_s), .data_i(pl3_in_s),
        .valid_o(v3_s), .ready_i(r4_s), .data_o(pl3_s)
    );
    add_chain_stage #(.DW(W)) u_s4 (
        .clk(clk), .rst(rst), .valid_i(v3_s), .ready_o(r4_s), .data_i(pl4_in_s),
        .valid_o(v4_s), .ready_i(out_ready), .data_o(pl4_s)
    );

    assign in_ready  = r1_s;
    assign out_valid = v4_s;
    assign out_data  = pl4_s;

`ifdef ADD_CHAIN_PIPE_CNT_EN
    logic [ADD_CHAIN_CNT_W-1:0] cnt_q;
    logic [ADD_CHAIN_CNT_W-1:0] cnt_d;

    // Count completed output transfers, wrapping naturally at the top.
    always_comb begin
        cnt_d = cnt_q;
        if (v4_s && out_ready) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_add_chain_pipe.sv
// Self-checking bench for add_chain_pipe: W=16/INC=1 and W=8/INC=3 instances,
// plus xfer_cnt checks when ADD_CHAIN_PIPE_CNT_EN is defined.
module tb_add_chain_pipe;
    import add_chain_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data, out_data;
    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  in_data8, out_data8;
`ifdef ADD_CHAIN_PIPE_CNT_EN
    logic [31:0] xfer_cnt, xfer_cnt8;
`endif

    int errors = 0;
    int checks = 0;

    add_chain_pipe #(.W(16), .INC(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef ADD_CHAIN_PIPE_CNT_EN
        , .xfer_cnt(xfer_cnt)
`endif
    );

    add_chain_pipe #(.W(8), .INC(3)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8)
`ifdef ADD_CHAIN_PIPE_CNT_EN
        , .xfer_cnt(xfer_cnt8)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain modular arithmetic straight from the chain definition.
    function automatic longint unsigned exp_model(input int w, input longint unsigned inc,
                                                  input longint unsigned d);
        longint unsigned mw, mh, t0l, t1, t2, t3;
        mw  = longint'(1) << w;
        mh  = longint'(1) << (w / 2);
        t0l = ((d + inc) % mw) % mh;
        t1  = (t0l + (d % mh)) % mh;
        t2  = (t1 + t0l) % mh;
        t3  = (t2 + t1) % mh;
        return t3 * mh + t2;
    endfunction

    // Scoreboard for the 16-bit instance.
    logic [15:0] q16[$];
    logic [31:0] exp_cnt16 = 32'd0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    always @(negedge clk) begin
        logic [15:0] e;
        logic [63:0] pk;
        if (rst) begin
            q16.delete();
            exp_cnt16 = 32'd0;
            prev_stall = 1'b0;
        end else begin
`ifdef ADD_CHAIN_PIPE_CNT_EN
            chk("xfer_cnt", xfer_cnt, exp_cnt16);
`endif
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            if (out_valid) chk("word_pending", q16.size() != 0, 1);
            if (out_valid && out_ready) begin
                exp_cnt16 = exp_cnt16 + 32'd1;
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    chk("out_data", out_data, e);
                end
            end
            if (in_valid && in_ready) begin
                e  = 16'(exp_model(16, 1, longint'(in_data)));
                pk = add_chain_ref(32'd16, 64'd1, {48'd0, in_data});
                chk("pkg_fn16", pk, {48'd0, e});
                q16.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // Scoreboard for the 8-bit instance.
    logic [7:0] q8[$];
    int         outs8 = 0;
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            q8.delete();
            outs8 = 0;
        end else begin
            if (out_valid8 && out_ready8) begin
                outs8++;
                chk("word_pending8", q8.size() != 0, 1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    chk("out_data8", out_data8, e);
                end
            end
            if (in_valid8 && in_ready8) q8.push_back(8'(exp_model(8, 3, longint'(in_data8))));
        end
    end

    task automatic send_one(input logic [15:0] d, input logic [15:0] lit, input string nm);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; out_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_accept"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4) begin
                chk({nm, "_early"}, out_valid, 0);
            end else begin
                chk({nm, "_latency"}, out_valid, 1);
                chk({nm, "_value"}, out_data, lit);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, gaps, acc, drained, seen, c;
        rst = 1'b1; in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b1;
        in_valid8 = 1'b0; in_data8 = 8'd0; out_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid8", out_valid8, 0);
`ifdef ADD_CHAIN_PIPE_CNT_EN
        chk("reset_xfer_cnt", xfer_cnt, 32'd0);
`endif

        send_one(16'h0005, 16'h1C11, "single");
        send_one(16'hFFFF, 16'hFEFF, "wrap_ffff");
        send_one(16'h00FF, 16'hFEFF, "wrap_00ff");
        send_one(16'h1234, 16'h079E, "wrap_1234");

        // Back-to-back stream of 100 words.
        sent = 0; gaps = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 16'($urandom); out_ready = 1'b1;
        for (c = 0; c < 108; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (c >= 4 && c <= 103 && !out_valid) gaps++;
            @(posedge clk); #1;
            if (sent >= 100) in_valid = 1'b0;
            in_data = 16'($urandom);
        end
        chk("stream_sent", sent, 100);
        chk("stream_gaps", gaps, 0);

        // Backpressure: fill, stall, then drain.
        acc = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (c = 0; c < 12; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            in_data = 16'($urandom);
        end
        @(negedge clk);
        chk("bp_accepts", acc, 4);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        drained = 0;
        for (c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) drained++;
            @(posedge clk); #1;
        end
        chk("bp_drained", drained, 4);
        in_valid = 1'b1;
        for (c = 0; c < 10; c++) begin
            in_data = 16'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Random valid/ready traffic; the scoreboard checks every transfer.
        for (c = 0; c < 300; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", q16.size(), 0);
        chk("drain_out_valid", out_valid, 0);

        // Reset with three words in flight.
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b1;
        for (c = 0; c < 3; c++) begin
            in_data = 16'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b1; in_data = 16'hABCD;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
`ifdef ADD_CHAIN_PIPE_CNT_EN
        chk("rst_xfer_cnt", xfer_cnt, 32'd0);
`endif
        seen = 0;
        for (c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_no_stale", seen, 0);

        // W=8, INC=3 instance: one pinned word then nine more under random out_ready.
        @(posedge clk); #1;
        in_valid8 = 1'b1; in_data8 = 8'h05; out_ready8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        for (c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid8) break;
        end
        chk("w8_valid", out_valid8, 1);
        chk("w8_value", out_data8, 8'h25);
        @(posedge clk); #1;
        sent = 0;
        for (c = 0; c < 200 && sent < 9; c++) begin
            in_valid8  = 1'b1;
            in_data8   = 8'($urandom);
            out_ready8 = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid8 && in_ready8) sent++;
            @(posedge clk); #1;
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("w8_outputs", outs8, 10);
`ifdef ADD_CHAIN_PIPE_CNT_EN
        chk("w8_xfer_cnt", xfer_cnt8, 32'd10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
